// File: rtl/control_sequencer_pkg.sv
// Shared state codes, strobe bundle and decode helpers for the multicycle
// control sequencer.
package control_sequencer_pkg;

    // Execute entries are the codes the instruction state encoder may
    // present at decode. Codes 17..28 are extra ALU entries and are handled
    // through is_alu_ext().
    typedef enum logic [6:0] {
        S_IDLE    = 7'd0,
        S_FETCH0  = 7'd1,
        S_FETCH1  = 7'd2,
        S_FETCH2  = 7'd3,
        S_DECODE  = 7'd4,
        S_ILLEGAL = 7'd5,
        S_ALU     = 7'd6,
        S_ST_ADDR = 7'd7,
        S_ST_DATA = 7'd8,
        S_ST_WAIT = 7'd9,
        S_BUS_ERR = 7'd10,
        S_BR_TEST = 7'd11,
        S_BR_TAKE = 7'd12,
        S_LD_ADDR = 7'd13,
        S_LD_WAIT = 7'd14,
        S_LD_WB   = 7'd15
    } state_t;

    localparam logic [6:0] ALU_EXT_FIRST = 7'd17;
    localparam logic [6:0] ALU_EXT_LAST  = 7'd28;

    typedef struct packed {
        logic mov;
        logic mem_rw;
        logic mar_ld;
        logic mar_sel;
        logic mdr_ld;
        logic ir_ld;
        logic pc_ld;
        logic pc_sel;
        logic rf_ld;
        logic rf_src;
        logic illegal;
        logic bus_err;
    } ctrl_t;

    function automatic logic is_alu_ext(input logic [6:0] code);
        return (code >= ALU_EXT_FIRST) && (code <= ALU_EXT_LAST);
    endfunction

    function automatic logic is_exec_entry(input logic [6:0] code);
        return (code == S_ALU) || (code == S_ST_ADDR) || (code == S_BR_TEST) ||
               (code == S_LD_ADDR) || is_alu_ext(code);
    endfunction

    function automatic logic is_wait_state(input logic [6:0] code);
        return (code == S_FETCH1) || (code == S_ST_WAIT) || (code == S_LD_WAIT);
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts cycles spent waiting for MOC in a memory-wait state and flags a
// timeout on the cycle whose edge would be the MOC_TIMEOUT-th without MOC.
module mem_watchdog #(
    parameter int unsigned MOC_TIMEOUT = 16
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic wait_entry,
    input  logic waiting,
    input  logic MOC,
    output logic timeout
);

    localparam int unsigned    CW    = $clog2(MOC_TIMEOUT) + 1;
    localparam logic [CW-1:0]  LIMIT = CW'(MOC_TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Clear on entry to a wait state, count MOC-less wait cycles, saturate.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_count <= '0;
        end else if (wait_entry) begin
            r_count <= '0;
        end else if (waiting && !MOC && (r_count != '1)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign timeout = waiting && !MOC && (r_count >= LIMIT);

endmodule

// File: rtl/control_sequencer.sv
// Multicycle MIPS control unit: fetch/decode/execute sequencing with Moore
// strobes and a memory-handshake watchdog.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int unsigned MOC_TIMEOUT = 16
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [6:0] State_Sel,
    input  logic       MOC,
    input  logic       Cond,
    output logic [6:0] State,
    output logic       MOV,
    output logic       MEM_RW,
    output logic       MAR_Ld,
    output logic       MAR_Sel,
    output logic       MDR_Ld,
    output logic       IR_Ld,
    output logic       PC_Ld,
    output logic       PC_Sel,
    output logic       RF_Ld,
    output logic       RF_Src,
    output logic       Illegal,
    output logic       Bus_Err
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    logic   w_waiting;
    logic   w_wait_entry;
    logic   w_timeout;

    assign w_waiting    = is_wait_state(r_state);
    assign w_wait_entry = is_wait_state(w_next) && !w_waiting;

    mem_watchdog #(
        .MOC_TIMEOUT(MOC_TIMEOUT)
    ) u_watchdog (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .wait_entry (w_wait_entry),
        .waiting    (w_waiting),
        .MOC        (MOC),
        .timeout    (w_timeout)
    );

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection; MOC takes priority over a same-edge timeout.
    // ALU execute codes and unused encodings all fall through to FETCH0.
    always_comb begin
        w_next = S_FETCH0;
        case (r_state)
            S_IDLE:    w_next = S_FETCH0;
            S_FETCH0:  w_next = S_FETCH1;
            S_FETCH1:  w_next = MOC ? S_FETCH2 : (w_timeout ? S_BUS_ERR : S_FETCH1);
            S_FETCH2:  w_next = S_DECODE;
            S_DECODE:  w_next = is_exec_entry(State_Sel) ? state_t'(State_Sel) : S_ILLEGAL;
            S_ILLEGAL: w_next = S_ILLEGAL;
            S_ST_ADDR: w_next = S_ST_DATA;
            S_ST_DATA: w_next = S_ST_WAIT;
            S_ST_WAIT: w_next = MOC ? S_FETCH0 : (w_timeout ? S_BUS_ERR : S_ST_WAIT);
            S_BUS_ERR: w_next = S_BUS_ERR;
            S_BR_TEST: w_next = Cond ? S_BR_TAKE : S_FETCH0;
            S_LD_ADDR: w_next = S_LD_WAIT;
            S_LD_WAIT: w_next = MOC ? S_LD_WB : (w_timeout ? S_BUS_ERR : S_LD_WAIT);
            default:   w_next = S_FETCH0;
        endcase
    end

    // Moore strobe decode of the registered state.
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            S_FETCH0: w_ctrl.mar_ld = 1'b1;
            S_FETCH1, S_LD_WAIT: begin
                w_ctrl.mov    = 1'b1;
                w_ctrl.mem_rw = 1'b1;
                w_ctrl.mdr_ld = 1'b1;
            end
            S_FETCH2: begin
                w_ctrl.ir_ld = 1'b1;
                w_ctrl.pc_ld = 1'b1;
            end
            S_ILLEGAL: w_ctrl.illegal = 1'b1;
            S_ALU:     w_ctrl.rf_ld   = 1'b1;
            S_ST_ADDR, S_LD_ADDR: begin
                w_ctrl.mar_ld  = 1'b1;
                w_ctrl.mar_sel = 1'b1;
            end
            S_ST_DATA: w_ctrl.mdr_ld  = 1'b1;
            S_ST_WAIT: w_ctrl.mov     = 1'b1;
            S_BUS_ERR: w_ctrl.bus_err = 1'b1;
            S_BR_TAKE: begin
                w_ctrl.pc_ld  = 1'b1;
                w_ctrl.pc_sel = 1'b1;
            end
            S_LD_WB: begin
                w_ctrl.rf_ld  = 1'b1;
                w_ctrl.rf_src = 1'b1;
            end
            default: w_ctrl.rf_ld = is_alu_ext(r_state);
        endcase
    end

    assign State   = r_state;
    assign MOV     = w_ctrl.mov;
    assign MEM_RW  = w_ctrl.mem_rw;
    assign MAR_Ld  = w_ctrl.mar_ld;
    assign MAR_Sel = w_ctrl.mar_sel;
    assign MDR_Ld  = w_ctrl.mdr_ld;
    assign IR_Ld   = w_ctrl.ir_ld;
    assign PC_Ld   = w_ctrl.pc_ld;
    assign PC_Sel  = w_ctrl.pc_sel;
    assign RF_Ld   = w_ctrl.rf_ld;
    assign RF_Src  = w_ctrl.rf_src;
    assign Illegal = w_ctrl.illegal;
    assign Bus_Err = w_ctrl.bus_err;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: a per-instruction reference model builds the expected
// state/strobe trace, a driver applies inputs and queues expectations, and a
// negedge monitor compares whatever the DUT presents.
module tb_control_sequencer;

    localparam int unsigned TO = 16;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [6:0] State_Sel = '0;
    logic       MOC = 1'b0;
    logic       Cond = 1'b0;
    logic [6:0] State;
    logic       MOV, MEM_RW, MAR_Ld, MAR_Sel, MDR_Ld, IR_Ld, PC_Ld, PC_Sel;
    logic       RF_Ld, RF_Src, Illegal, Bus_Err;

    control_sequencer #(.MOC_TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .State_Sel(State_Sel), .MOC(MOC), .Cond(Cond),
        .State(State), .MOV(MOV), .MEM_RW(MEM_RW), .MAR_Ld(MAR_Ld), .MAR_Sel(MAR_Sel),
        .MDR_Ld(MDR_Ld), .IR_Ld(IR_Ld), .PC_Ld(PC_Ld), .PC_Sel(PC_Sel), .RF_Ld(RF_Ld),
        .RF_Src(RF_Src), .Illegal(Illegal), .Bus_Err(Bus_Err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed { logic [6:0] st; logic [11:0] ctl; } exp_t;
    typedef struct { logic [6:0] sel; logic moc; logic cond; exp_t e; } cyc_t;

    cyc_t plan[$];
    exp_t expq[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Strobe order: MOV MEM_RW MAR_Ld MAR_Sel MDR_Ld IR_Ld PC_Ld PC_Sel RF_Ld RF_Src Illegal Bus_Err
    function automatic logic [11:0] spec_ctl(input logic [6:0] s);
        case (s)
            7'd1:  return 12'b0010_0000_0000;
            7'd2:  return 12'b1100_1000_0000;
            7'd3:  return 12'b0000_0110_0000;
            7'd5:  return 12'b0000_0000_0010;
            7'd6:  return 12'b0000_0000_1000;
            7'd7:  return 12'b0011_0000_0000;
            7'd8:  return 12'b0000_1000_0000;
            7'd9:  return 12'b1000_0000_0000;
            7'd10: return 12'b0000_0000_0001;
            7'd12: return 12'b0000_0011_0000;
            7'd13: return 12'b0011_0000_0000;
            7'd14: return 12'b1100_1000_0000;
            7'd15: return 12'b0000_0000_1100;
            default: return (s >= 7'd17 && s <= 7'd28) ? 12'b0000_0000_1000 : 12'b0;
        endcase
    endfunction

    function automatic bit defined_entry(input int unsigned c);
        return (c == 6) || (c == 7) || (c == 11) || (c == 13) || (c >= 17 && c <= 28);
    endfunction

    function automatic logic [18:0] dut_vec();
        return {State, MOV, MEM_RW, MAR_Ld, MAR_Sel, MDR_Ld, IR_Ld, PC_Ld, PC_Sel,
                RF_Ld, RF_Src, Illegal, Bus_Err};
    endfunction

    task automatic add(input int unsigned st, input int unsigned sel, input bit moc, input bit cond);
        cyc_t c;
        c.sel = 7'(sel);
        c.moc = moc;
        c.cond = cond;
        c.e.st = 7'(st);
        c.e.ctl = spec_ctl(7'(st));
        plan.push_back(c);
    endtask

    // Cycle whose inputs are irrelevant: drive noise on every input.
    task automatic add_n(input int unsigned st);
        add(st, $urandom_range(0, 127), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic add_sel(input int unsigned st, input int unsigned sel);
        add(st, sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic hold(input int unsigned st, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) add_n(st);
    endtask

    // MOC arrives after d idle wait cycles; more than TO-1 idle cycles is a bus error.
    task automatic mem_wait(input int unsigned ws, input int unsigned d, output bit timed_out);
        timed_out = 1'b0;
        if (d < TO) begin
            for (int unsigned k = 0; k <= d; k++)
                add(ws, $urandom_range(0, 127), (k == d), 1'($urandom_range(0, 1)));
        end else begin
            for (int unsigned k = 0; k < TO; k++)
                add(ws, $urandom_range(0, 127), 1'b0, 1'($urandom_range(0, 1)));
            timed_out = 1'b1;
        end
    endtask

    function automatic int unsigned pick_delay();
        int unsigned r = $urandom_range(0, 15);
        if (r < 12)  return $urandom_range(0, 4);
        if (r == 12) return TO - 1;
        if (r == 13) return TO - 2;
        if (r == 14) return TO;
        return TO + $urandom_range(0, 5);
    endfunction

    // kind: 0 ALU, 1 load, 2 store, 3 branch taken, 4 branch not taken, 5 illegal
    task automatic gen_instr(input int unsigned kind, input int unsigned df,
                             input int unsigned dm, output bit term);
        bit to;
        int unsigned code;
        term = 1'b0;
        add_n(1);
        mem_wait(2, df, to);
        if (to) begin hold(10, $urandom_range(3, 12)); term = 1'b1; return; end
        add_n(3);
        case (kind)
            0: begin
                code = $urandom_range(0, 12);
                code = (code == 0) ? 6 : 16 + code;
                add_sel(4, code);
                add_n(code);
            end
            1: begin
                add_sel(4, 13); add_n(13);
                mem_wait(14, dm, to);
                if (to) begin hold(10, $urandom_range(3, 12)); term = 1'b1; end
                else add_n(15);
            end
            2: begin
                add_sel(4, 7); add_n(7); add_n(8);
                mem_wait(9, dm, to);
                if (to) begin hold(10, $urandom_range(3, 12)); term = 1'b1; end
            end
            3, 4: begin
                add_sel(4, 11);
                add(11, $urandom_range(0, 127), 1'($urandom_range(0, 1)), (kind == 3));
                if (kind == 3) add_n(12);
            end
            default: begin
                if ($urandom_range(0, 1) == 0) code = 0;
                else begin
                    code = $urandom_range(1, 127);
                    while (defined_entry(code)) code = $urandom_range(1, 127);
                end
                add_sel(4, code);
                hold(5, 20);
                term = 1'b1;
            end
        endcase
    endtask

    task automatic check_reset(input string name);
        n_vec++;
        if (dut_vec() !== 19'b0) begin
            n_bad++;
            $display("FAIL %s: got State=%0d strobes=%b, want State=0 strobes=0",
                     name, State, dut_vec() & 19'h0FFF);
        end
    endtask

    // Apply the planned trace from reset release, then reset mid-cycle.
    task automatic run_plan();
        foreach (plan[i]) begin
            State_Sel = plan[i].sel;
            MOC = plan[i].moc;
            Cond = plan[i].cond;
            expq.push_back(plan[i].e);
            if (i + 1 < plan.size()) begin @(posedge Clk); #1; end
        end
        @(negedge Clk); #1;
        Reset_n = 1'b0;
        #1;
        check_reset("async_reset");
        @(posedge Clk); #2;
        check_reset("reset_held");
        Reset_n = 1'b1;
    endtask

    task automatic segment(input int kind, input int unsigned df, input int unsigned dm,
                           input int unsigned max_instr, input bit allow_cut);
        bit term;
        int unsigned k;
        plan.delete();
        add_n(0);
        term = 1'b0;
        for (int unsigned n = 0; n < max_instr && !term; n++) begin
            if (kind >= 0) k = kind;
            else begin
                k = $urandom_range(0, 19);
                k = (k < 8) ? 0 : (k < 11) ? 1 : (k < 14) ? 2 : (k < 16) ? 3 :
                    (k < 19) ? 4 : 5;
            end
            gen_instr(k, (kind >= 0) ? df : pick_delay(), (kind >= 0) ? dm : pick_delay(), term);
        end
        if (allow_cut && $urandom_range(0, 1) == 1)
            while (plan.size() > 1 && $urandom_range(0, 7) != 0) void'(plan.pop_back());
        run_plan();
    endtask

    // Monitor: compare every presented cycle against the head of the scoreboard.
    always @(negedge Clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            n_vec++;
            if (dut_vec() !== {e.st, e.ctl}) begin
                n_bad++;
                $display("FAIL seq: got State=%0d strobes=%b, want State=%0d strobes=%b",
                         State, dut_vec() & 19'h0FFF, e.st, e.ctl);
            end
        end
    end

    initial begin
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        check_reset("power_on_reset");
        Reset_n = 1'b1;
        segment(0, 0, 0, 1, 1'b0);        // ALU, zero-wait fetch
        segment(1, 0, 3, 1, 1'b0);        // load, MOC after 3 idle cycles
        segment(3, 0, 0, 1, 1'b0);        // branch taken
        segment(4, 0, 0, 1, 1'b0);        // branch not taken
        segment(5, 1, 0, 1, 1'b0);        // illegal at decode
        segment(2, 0, TO, 1, 1'b0);       // store, MOC never arrives
        segment(2, 0, TO - 1, 1, 1'b0);   // store, MOC on the last allowed cycle
        segment(0, TO + 3, 0, 1, 1'b0);   // fetch timeout
        for (int s = 0; s < 40; s++) segment(-1, 0, 0, $urandom_range(1, 8), 1'b1);
        repeat (2) @(posedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL time_limit: bench still running at 2 ms, want completion");
        $fatal(1, "time limit");
    end

endmodule
